// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : collision_scanner
// Purpose  : Time-multiplexed doodle-vs-platform landing search, LANES/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module collision_scanner #(
  parameter int N_PLAT      = 93,
  parameter int LANES       = 4,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int HIT_TOP     = 80,
  parameter int HIT_BOT     = 50,
  parameter int HIT_LEFT    = 61,
  parameter int HIT_RIGHT   = 80,
  parameter int FLOOR_Y     = 767,
  parameter int SCROLL_LINE = 420
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [N_PLAT*Y_W-1:0]     i_plat_y,
  input  logic [N_PLAT*X_W-1:0]     i_plat_x,
  input  logic [N_PLAT*2-1:0]       i_plat_type,
  input  logic [N_PLAT-1:0]         i_plat_active,
  input  logic [X_W-1:0]            i_doodle_x,
  input  logic [Y_W-1:0]            i_doodle_y,
  input  logic                      i_falling,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_hit,
  output logic                      o_floor_hit,
  output logic [$clog2(N_PLAT)-1:0] o_hit_idx,
  output logic [1:0]                o_hit_type,
  output logic [Y_W-1:0]            o_ground_y,
  output logic [X_W-1:0]            o_ground_x,
  output logic                      o_scroll_req,
  output logic                      o_break_valid,
  output logic [$clog2(N_PLAT)-1:0] o_break_idx
);

  localparam int c_NCYC  = (N_PLAT + LANES - 1) / LANES;
  localparam int c_IDX_W = $clog2(N_PLAT);
  localparam int c_BASE_W = $clog2(c_NCYC * LANES + 1);
  localparam int c_CYC_W = $clog2(c_NCYC + 1);
  localparam int c_S_W   = ((X_W > Y_W) ? X_W : Y_W) + 2;

  localparam logic signed [c_S_W-1:0] c_TOP   = c_S_W'(HIT_TOP);
  localparam logic signed [c_S_W-1:0] c_BOT   = c_S_W'(HIT_BOT);
  localparam logic signed [c_S_W-1:0] c_LEFT  = c_S_W'(HIT_LEFT);
  localparam logic signed [c_S_W-1:0] c_RIGHT = c_S_W'(HIT_RIGHT);
  localparam logic signed [c_S_W-1:0] c_FLOOR_THR = c_S_W'(FLOOR_Y - HIT_TOP);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SCAN   = 2'd1;
  localparam logic [1:0] c_REPORT = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                w_accept;
  logic                w_scan;
  logic                w_report;

  logic [X_W-1:0]      r_dx;
  logic [Y_W-1:0]      r_dy;
  logic                r_fall;
  logic [c_BASE_W-1:0] r_base;
  logic [c_CYC_W-1:0]  r_cyc;

  logic                r_best_v;
  logic [Y_W-1:0]      r_best_y;
  logic [X_W-1:0]      r_best_x;
  logic [c_IDX_W-1:0]  r_best_idx;
  logic [1:0]          r_best_type;
  logic                r_brk_v;
  logic [c_IDX_W-1:0]  r_brk_idx;

  logic [Y_W-1:0]      w_py [LANES];
  logic [X_W-1:0]      w_px [LANES];
  logic [1:0]          w_pt [LANES];
  logic [c_IDX_W-1:0]  w_pi [LANES];
  logic [LANES-1:0]    w_norm;
  logic [LANES-1:0]    w_brk;

  logic signed [c_S_W-1:0] w_sdx;
  logic signed [c_S_W-1:0] w_sdy;

  assign w_sdx = $signed(c_S_W'(r_dx));
  assign w_sdy = $signed(c_S_W'(r_dy));

  // Widened signed window compare so low platforms cannot wrap into a match
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [c_BASE_W-1:0]     w_slot;
    logic                    w_inr;
    logic [c_IDX_W-1:0]      w_sidx;
    logic signed [c_S_W-1:0] w_sy;
    logic signed [c_S_W-1:0] w_sx;
    logic                    w_win;
    logic                    w_cand;

    assign w_slot  = r_base + c_BASE_W'(l);
    assign w_inr   = (w_slot < c_BASE_W'(N_PLAT));
    assign w_sidx  = w_inr ? w_slot[c_IDX_W-1:0] : '0;
    assign w_py[l] = i_plat_y[w_sidx*Y_W +: Y_W];
    assign w_px[l] = i_plat_x[w_sidx*X_W +: X_W];
    assign w_pt[l] = i_plat_type[w_sidx*2 +: 2];
    assign w_pi[l] = w_sidx;
    assign w_sy    = $signed(c_S_W'(w_py[l]));
    assign w_sx    = $signed(c_S_W'(w_px[l]));
    assign w_win   = (w_sy - c_TOP <= w_sdy) && (w_sdy <= w_sy - c_BOT) &&
                     (w_sx - c_LEFT <= w_sdx) && (w_sdx <= w_sx + c_RIGHT);
    assign w_cand  = w_inr & i_plat_active[w_sidx] & r_fall & w_win;
    assign w_norm[l] = w_cand & (w_pt[l] != 2'd2);
    assign w_brk[l]  = w_cand & (w_pt[l] == 2'd2);
  end

  logic               w_lf;
  logic [Y_W-1:0]     w_ly;
  logic [X_W-1:0]     w_lx;
  logic [c_IDX_W-1:0] w_li;
  logic [1:0]         w_lt;
  logic               w_bf;
  logic [c_IDX_W-1:0] w_bi;

  // Lanes walk in ascending slot order, so strict "<" keeps the lowest index on ties
  always_comb begin
    w_lf = 1'b0;
    w_ly = '0;
    w_lx = '0;
    w_li = '0;
    w_lt = '0;
    w_bf = 1'b0;
    w_bi = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_norm[l] && (!w_lf || (w_py[l] < w_ly))) begin
        w_lf = 1'b1;
        w_ly = w_py[l];
        w_lx = w_px[l];
        w_li = w_pi[l];
        w_lt = w_pt[l];
      end
      if (w_brk[l] && !w_bf) begin
        w_bf = 1'b1;
        w_bi = w_pi[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (i_start) w_next = c_SCAN;
      c_SCAN:   if (r_cyc == c_CYC_W'(c_NCYC - 1)) w_next = c_REPORT;
      c_REPORT: w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_scan   = 1'b0;
    w_report = 1'b0;
    case (r_state)
      c_IDLE:   w_accept = i_start;
      c_SCAN:   w_scan   = 1'b1;
      c_REPORT: w_report = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx          <= '0;
      r_dy          <= '0;
      r_fall        <= 1'b0;
      r_base        <= '0;
      r_cyc         <= '0;
      r_best_v      <= 1'b0;
      r_best_y      <= '0;
      r_best_x      <= '0;
      r_best_idx    <= '0;
      r_best_type   <= '0;
      r_brk_v       <= 1'b0;
      r_brk_idx     <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hit         <= 1'b0;
      o_floor_hit   <= 1'b0;
      o_hit_idx     <= '0;
      o_hit_type    <= '0;
      o_ground_y    <= Y_W'(FLOOR_Y);
      o_ground_x    <= '0;
      o_scroll_req  <= 1'b0;
      o_break_valid <= 1'b0;
      o_break_idx   <= '0;
    end else begin
      o_done <= 1'b0;
      if (w_accept) begin
        r_dx     <= i_doodle_x;
        r_dy     <= i_doodle_y;
        r_fall   <= i_falling;
        r_base   <= '0;
        r_cyc    <= '0;
        r_best_v <= 1'b0;
        r_brk_v  <= 1'b0;
        r_brk_idx <= '0;
        o_busy   <= 1'b1;
      end
      if (w_scan) begin
        r_base <= r_base + c_BASE_W'(LANES);
        r_cyc  <= r_cyc + 1'b1;
        // Earlier cycles hold lower indices, so only a strictly higher platform replaces
        if (w_lf && (!r_best_v || (w_ly < r_best_y))) begin
          r_best_v    <= 1'b1;
          r_best_y    <= w_ly;
          r_best_x    <= w_lx;
          r_best_idx  <= w_li;
          r_best_type <= w_lt;
        end
        if (w_bf && !r_brk_v) begin
          r_brk_v   <= 1'b1;
          r_brk_idx <= w_bi;
        end
      end
      if (w_report) begin
        if (r_best_v) begin
          o_hit        <= 1'b1;
          o_floor_hit  <= 1'b0;
          o_ground_y   <= r_best_y;
          o_ground_x   <= r_best_x;
          o_hit_idx    <= r_best_idx;
          o_hit_type   <= r_best_type;
          o_scroll_req <= (r_best_y < Y_W'(SCROLL_LINE));
        end else if ((o_ground_y == Y_W'(FLOOR_Y)) && (w_sdy > c_FLOOR_THR)) begin
          o_hit        <= 1'b1;
          o_floor_hit  <= 1'b1;
          o_ground_y   <= Y_W'(FLOOR_Y);
          o_scroll_req <= 1'b0;
        end else begin
          o_hit        <= 1'b0;
          o_floor_hit  <= 1'b0;
          o_scroll_req <= 1'b0;
        end
        o_break_valid <= r_brk_v;
        o_break_idx   <= r_brk_idx;
        o_done        <= 1'b1;
        o_busy        <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised, time-multiplexed doodle-vs-platform collision engine.
- Once per frame, on a start strobe, it scans N_PLAT platforms, LANES per cycle, against a snapshot of the doodle position.
- Selects a single landing platform and reports ground, scroll request, spring/breakable events and floor contact to the physics and scroll logic.
- Replaces the fully parallel single-cycle compare with a bounded-area, deterministic-latency pipeline.

Parameters:
- N_PLAT, 93, number of platform slots
- LANES, 4, platforms compared per scan cycle (1..N_PLAT)
- X_W, 11, doodle/platform x width
- Y_W, 10, doodle y width; platform y also Y_W
- HIT_TOP, 80, window upper offset: plat_y-HIT_TOP <= dy
- HIT_BOT, 50, window lower offset: dy <= plat_y-HIT_BOT
- HIT_LEFT, 61, window left offset: plat_x-HIT_LEFT <= dx
- HIT_RIGHT, 80, window right offset: dx <= plat_x+HIT_RIGHT
- FLOOR_Y, 767, ground value meaning "on floor"
- SCROLL_LINE, 420, ground_y below this raises scroll_req

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame strobe, accepted only in IDLE
- plat_y  in  N_PLAT*Y_W  per-slot platform top y
- plat_x  in  N_PLAT*X_W  per-slot platform x
- plat_type  in  N_PLAT*2  0 normal, 1 spring, 2 breakable, 3 treated as normal
- plat_active  in  N_PLAT  slot valid
- doodle_x  in  X_W  doodle x
- doodle_y  in  Y_W  doodle y
- falling  in  1  doodle moving downward
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, results valid
- hit  out  1  landing this frame (platform or floor)
- floor_hit  out  1  landing is the floor
- hit_idx  out  $clog2(N_PLAT)  landed slot
- hit_type  out  2  type of landed slot
- ground_y  out  Y_W  current ground y, held across frames
- ground_x  out  X_W  current ground x
- scroll_req  out  1  landed platform above SCROLL_LINE
- break_valid  out  1  breakable platform touched
- break_idx  out  $clog2(N_PLAT)  touched breakable slot

Behaviour:
- Reset values: busy=0, done=0, hit=0, floor_hit=0, hit_idx=0, hit_type=0, ground_y=FLOOR_Y, ground_x=0, scroll_req=0, break_valid=0, break_idx=0. FSM goes to IDLE.
- Reset mid-scan aborts the scan with no report.
- FSM states: IDLE, SCAN, REPORT.
- IDLE, start=1:
  - Latch doodle_x, doodle_y, falling into snapshot regs.
  - Clear the best-candidate and break-candidate registers.
  - base=0, busy=1, go to SCAN.
- start while busy is ignored.
- SCAN, each cycle:
  - Evaluate slots base..base+LANES-1; slots >= N_PLAT are masked.
  - base += LANES.
  - After NCYC=ceil(N_PLAT/LANES) cycles, go to REPORT.
- Candidate condition: plat_active & falling_snap & window test.
- Window test arithmetic: signed, width max(X_W,Y_W)+2, so no wrap when plat_y<HIT_TOP or plat_x<HIT_LEFT.
- Landing selection among non-breakable candidates:
  - Smallest plat_y wins.
  - Tie goes to the lowest index.
  - Intra-lane compare uses the same rule.
- Breakable candidates never land. The lowest-index breakable candidate is recorded for the break report.
- REPORT (one cycle; outputs registered and valid when done=1):
  - If a landing candidate exists: hit=1, floor_hit=0, ground_y/ground_x/hit_idx/hit_type from the winner; scroll_req = (winner plat_y < SCROLL_LINE). The new ground is used, not the previous one.
  - Else if ground_y==FLOOR_Y and doodle_y_snap > FLOOR_Y-HIT_TOP: hit=1, floor_hit=1, ground_y=FLOOR_Y, scroll_req=0.
  - Else: hit=0, scroll_req=0, ground unchanged.
  - break_valid/break_idx come from the break candidate.
  - done=1, busy=0, go to IDLE.
- hit, floor_hit, scroll_req, break_valid hold until the next REPORT.
- done is a single-cycle pulse.
- Latency: done asserts NCYC+1 cycles after the start-accept edge (25 for the defaults).
- Platform arrays must be stable from start until done; the caller guarantees this, and the block does not snapshot them.

Test Plan:
- Reset, then start with all slots inactive and doodle_y=700, falling=1 -> done at cycle 25; hit=1, floor_hit=1, ground_y=767, scroll_req=0.
- Slot 5 active normal, y=500, x=300; doodle (320,440), falling=1 -> hit=1, hit_idx=5, ground_y=500, ground_x=300, scroll_req=0. Repeat with falling=0 -> hit=0, ground_y remains 500.
- Slots 10 (y=470, x=300) and 40 (y=460, x=300) active; doodle (300,400) -> hit_idx=40, ground_y=460. Same y=460 on both -> hit_idx=10.
- Slot 3, type spring, y=400, x=100; doodle (100,340) -> hit=1, hit_type=1, scroll_req=1. Slot at y=30 with doodle_y=0 -> no spurious wrap-around hit.
- Slot 7, type breakable, in window, no other candidates -> hit=0, break_valid=1, break_idx=7, ground unchanged.
- Start pulsed again at scan cycle 5 -> ignored, done still at 25. rst at scan cycle 10 -> all outputs at reset values, no done. LANES=1 and LANES=93 builds -> done at 94 and 2 cycles respectively.
